// File: rtl/fifo_level.sv
// fifo_level: single-clock first-word-fall-through FIFO with arbitrary depth,
// occupancy count, programmable almost-full/almost-empty thresholds,
// full-and-pop pass-through and sticky overflow/underflow flags.
module fifo_level #(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned SIZE      = 128,
   parameter int unsigned AFULL_TH  = 120,
   parameter int unsigned AEMPTY_TH = 8
) (
   input  logic                       iCLK,
   input  logic                       iRST,
   input  logic [WIDTH-1:0]           iData,
   input  logic                       iPush,
   output logic                       oFull,
   output logic                       oAlmostFull,
   output logic [WIDTH-1:0]           oData,
   input  logic                       iPop,
   output logic                       oEmpty,
   output logic                       oAlmostEmpty,
   output logic [$clog2(SIZE+1)-1:0]  oCount,
   input  logic                       iClrErr,
   output logic                       oOverflow,
   output logic                       oUnderflow
);

   localparam int unsigned AW = $clog2(SIZE);
   localparam int unsigned CW = $clog2(SIZE+1);

   localparam logic [AW-1:0] PTR_LAST  = AW'(SIZE - 1);
   localparam logic [CW-1:0] CNT_FULL  = CW'(SIZE);
   localparam logic [CW-1:0] CNT_AFULL = CW'(AFULL_TH);
   localparam logic [CW-1:0] CNT_AEMPT = CW'(AEMPTY_TH);

   // Storage (not reset) and state registers
   logic [WIDTH-1:0] mem_q [SIZE];

   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q,  count_d;
   logic             empty_q,  empty_d;
   logic             full_q,   full_d;
   logic             aempty_q, aempty_d;
   logic             afull_q,  afull_d;
   logic             ovf_q,    ovf_d;
   logic             unf_q,    unf_d;

   logic             pop_ok;
   logic             push_ok;

   // Accept/reject decisions; a pop frees a slot so a full FIFO can take a push
   always_comb begin
      pop_ok  = iPop & ~empty_q;
      push_ok = iPush & (~full_q | pop_ok);
   end

   // Pointer advance with explicit wrap so any depth works
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push_ok) begin
         wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + AW'(1);
      end
      if (pop_ok) begin
         rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + AW'(1);
      end
   end

   // Next occupancy and the level flags derived from it, so flags register
   // coherently with the count and never see iPush/iPop combinationally
   always_comb begin
      count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
      empty_d  = (count_d == '0);
      full_d   = (count_d == CNT_FULL);
      afull_d  = (count_d >= CNT_AFULL);
      aempty_d = (count_d <= CNT_AEMPT);
   end

   // Sticky error flags: a new event wins over a simultaneous clear
   always_comb begin
      ovf_d = ovf_q;
      unf_d = unf_q;
      if (iClrErr) begin
         ovf_d = 1'b0;
         unf_d = 1'b0;
      end
      if (iPush & ~push_ok) begin
         ovf_d = 1'b1;
      end
      if (iPop & empty_q) begin
         unf_d = 1'b1;
      end
   end

   // State registers with asynchronous reset
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         empty_q  <= 1'b1;
         full_q   <= 1'b0;
         aempty_q <= 1'b1;
         afull_q  <= 1'b0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         empty_q  <= empty_d;
         full_q   <= full_d;
         aempty_q <= aempty_d;
         afull_q  <= afull_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
      end
   end

   // Memory write on accepted push; contents deliberately left unreset
   always_ff @(posedge iCLK) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= iData;
      end
   end

   // Output drive: head word is read combinationally (first-word-fall-through)
   always_comb begin
      oData        = mem_q[rd_ptr_q];
      oCount       = count_q;
      oEmpty       = empty_q;
      oFull        = full_q;
      oAlmostEmpty = aempty_q;
      oAlmostFull  = afull_q;
      oOverflow    = ovf_q;
      oUnderflow   = unf_q;
   end

endmodule

// File: tb/tb_fifo_level.sv
// tb_fifo_level: directed test of fifo_level (SIZE=5) against a queue model.
module tb_fifo_level;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned SIZE  = 5;
   localparam int unsigned AFT   = 4;
   localparam int unsigned AET   = 1;
   localparam int unsigned CW    = $clog2(SIZE+1);

   logic             iCLK = 1'b0;
   logic             iRST;
   logic [WIDTH-1:0] iData;
   logic             iPush;
   logic             iPop;
   logic             iClrErr;
   logic             oFull, oAlmostFull, oEmpty, oAlmostEmpty;
   logic [WIDTH-1:0] oData;
   logic [CW-1:0]    oCount;
   logic             oOverflow, oUnderflow;

   int tests  = 0;
   int errors = 0;

   // Reference model: queue contents and sticky flags
   logic [WIDTH-1:0] mq[$];
   bit               m_ovf, m_unf;

   fifo_level #(
      .WIDTH    (WIDTH),
      .SIZE     (SIZE),
      .AFULL_TH (AFT),
      .AEMPTY_TH(AET)
   ) dut (
      .iCLK        (iCLK),
      .iRST        (iRST),
      .iData       (iData),
      .iPush       (iPush),
      .oFull       (oFull),
      .oAlmostFull (oAlmostFull),
      .oData       (oData),
      .iPop        (iPop),
      .oEmpty      (oEmpty),
      .oAlmostEmpty(oAlmostEmpty),
      .oCount      (oCount),
      .iClrErr     (iClrErr),
      .oOverflow   (oOverflow),
      .oUnderflow  (oUnderflow)
   );

   always #5 iCLK = ~iCLK;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
   endtask

   // One clock of stimulus; model advances from its own state at the edge
   task automatic step(input bit push, input int data, input bit pop, input bit clr);
      bit pop_ok, push_ok;
      iPush   = push;
      iData   = WIDTH'(data);
      iPop    = pop;
      iClrErr = clr;
      @(posedge iCLK);
      if (!iRST) begin
         pop_ok  = pop && (mq.size() > 0);
         push_ok = push && ((mq.size() < SIZE) || pop_ok);
         if (clr) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
         end
         if (push && !push_ok) m_ovf = 1'b1;
         if (pop && mq.size() == 0) m_unf = 1'b1;
         if (pop_ok) void'(mq.pop_front());
         if (push_ok) mq.push_back(WIDTH'(data));
      end
      #1;
      iPush   = 1'b0;
      iPop    = 1'b0;
      iClrErr = 1'b0;
   endtask

   // Per-cycle comparison against the model on the falling edge
   always @(negedge iCLK) begin
      int n;
      n = mq.size();
      chk("cyc.count",  int'(oCount),       n);
      chk("cyc.empty",  int'(oEmpty),       int'(n == 0));
      chk("cyc.full",   int'(oFull),        int'(n == SIZE));
      chk("cyc.afull",  int'(oAlmostFull),  int'(n >= AFT));
      chk("cyc.aempty", int'(oAlmostEmpty), int'(n <= AET));
      chk("cyc.ovf",    int'(oOverflow),    int'(m_ovf));
      chk("cyc.unf",    int'(oUnderflow),   int'(m_unf));
      if (n > 0) chk("cyc.data", int'(oData), int'(mq[0]));
   end

   initial begin
      int exp_drain[5];
      exp_drain = '{2, 3, 4, 5, 'hA};
      iRST = 1'b1; iData = '0; iPush = 1'b0; iPop = 1'b0; iClrErr = 1'b0;
      model_reset();
      repeat (2) @(negedge iCLK);
      #1;
      // 1: reset state
      chk("rst.empty",  int'(oEmpty), 1);
      chk("rst.aempty", int'(oAlmostEmpty), 1);
      chk("rst.count",  int'(oCount), 0);
      chk("rst.full",   int'(oFull), 0);
      #2 iRST = 1'b0;

      // 2: fill and overflow
      for (int i = 1; i <= 5; i++) begin
         step(1'b1, i, 1'b0, 1'b0);
         chk("fill.count",  int'(oCount), i);
         chk("fill.aempty", int'(oAlmostEmpty), int'(i <= 1));
         chk("fill.afull",  int'(oAlmostFull), int'(i >= 4));
         chk("fill.full",   int'(oFull), int'(i == 5));
      end
      step(1'b1, 6, 1'b0, 1'b0);
      chk("ovf.flag",  int'(oOverflow), 1);
      chk("ovf.count", int'(oCount), 5);
      step(1'b0, 0, 1'b0, 1'b1);
      chk("ovf.clr", int'(oOverflow), 0);

      // 3: full pass-through push+pop, then drain across the wrap
      chk("pass.head", int'(oData), 1);
      step(1'b1, 'hA, 1'b1, 1'b0);
      chk("pass.count", int'(oCount), 5);
      chk("pass.full",  int'(oFull), 1);
      chk("pass.ovf",   int'(oOverflow), 0);
      for (int i = 0; i < 5; i++) begin
         chk("drain.data", int'(oData), exp_drain[i]);
         step(1'b0, 0, 1'b1, 1'b0);
      end
      chk("drain.empty", int'(oEmpty), 1);

      // 4: push+pop while empty
      step(1'b1, 7, 1'b1, 1'b0);
      chk("ep.count", int'(oCount), 1);
      chk("ep.unf",   int'(oUnderflow), 1);
      chk("ep.data",  int'(oData), 7);

      // 5: clear, then clear coinciding with pop-on-empty
      step(1'b0, 0, 1'b0, 1'b1);
      chk("clr.ovf", int'(oOverflow), 0);
      chk("clr.unf", int'(oUnderflow), 0);
      step(1'b0, 0, 1'b1, 1'b0);
      step(1'b0, 0, 1'b1, 1'b1);
      chk("clrset.unf", int'(oUnderflow), 1);

      // 6: async reset mid-cycle with three words queued
      step(1'b1, 'h11, 1'b0, 1'b0);
      step(1'b1, 'h22, 1'b0, 1'b0);
      step(1'b1, 'h33, 1'b0, 1'b0);
      chk("ar.pre", int'(oCount), 3);
      #2 iRST = 1'b1;
      model_reset();
      #1;
      chk("ar.count",  int'(oCount), 0);
      chk("ar.empty",  int'(oEmpty), 1);
      chk("ar.aempty", int'(oAlmostEmpty), 1);
      chk("ar.full",   int'(oFull), 0);
      chk("ar.afull",  int'(oAlmostFull), 0);
      chk("ar.unf",    int'(oUnderflow), 0);
      @(negedge iCLK);
      #2 iRST = 1'b0;
      step(1'b1, 'h55, 1'b0, 1'b0);
      chk("ar.data",   int'(oData), 'h55);
      chk("ar.count1", int'(oCount), 1);
      step(1'b0, 0, 1'b1, 1'b0);
      chk("ar.final", int'(oEmpty), 1);

      @(negedge iCLK);
      #1;
      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule
